// File: rtl/uart_loopback_fifo.sv
// Buffered UART loopback: received words queue in a DEPTH-entry FIFO and drain to the sender
// through a mode-selected transform. Optional statistics counters: define LOOPBACK_STATS_EN.
module uart_loopback_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       rx_data,
  input  logic                   rx_valid,
  input  logic                   tx_idle,
  input  logic [1:0]             mode,
  input  logic                   clr_ovf,
  output logic [WIDTH-1:0]       tx_data,
  output logic                   tx_start,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   empty,
  output logic                   full,
  output logic                   ovf,
  output logic [15:0]            rx_cnt,
  output logic [15:0]            tx_cnt,
  output logic [15:0]            drop_cnt,
  output logic [1:0]             dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [WIDTH-1:0] UC_A     = WIDTH'(8'h41);
  localparam logic [WIDTH-1:0] UC_Z     = WIDTH'(8'h5A);
  localparam logic [WIDTH-1:0] LC_A     = WIDTH'(8'h61);
  localparam logic [WIDTH-1:0] LC_Z     = WIDTH'(8'h7A);
  localparam logic [WIDTH-1:0] CASE_BIT = WIDTH'(8'h20);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_IDLE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             tx_start_q;
  logic             ovf_q, ovf_d;
  logic             empty_w, full_w;
  logic             send, discard, pop, push, drop;

  function automatic logic [WIDTH-1:0] xform(input logic [1:0] m, input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    r = w;
    if (m == 2'b01) begin
      r = ~w;
    end else if (m == 2'b10 && WIDTH == 8 &&
                 ((w >= UC_A && w <= UC_Z) || (w >= LC_A && w <= LC_Z))) begin
      r = w ^ CASE_BIT;
    end
    return r;
  endfunction

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));

  // Only IDLE pops; discard mode drains one word per cycle without involving the sender.
  always_comb begin
    state_d = state_q;
    send    = 1'b0;
    discard = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_w) begin
          if (mode == 2'b11) begin
            discard = 1'b1;
          end else if (tx_idle) begin
            send    = 1'b1;
            state_d = WAIT_BUSY;
          end
        end
      end
      WAIT_BUSY: if (!tx_idle) state_d = WAIT_IDLE;
      WAIT_IDLE: if (tx_idle)  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // A full FIFO still accepts a word when a pop frees a slot in the same cycle.
  always_comb begin
    pop       = send | discard;
    push      = rx_valid & (~full_w | pop);
    drop      = rx_valid & ~push;
    ovf_d     = drop | (ovf_q & ~clr_ovf);
    tx_data_d = send ? xform(mode, mem_q[rd_ptr_q]) : tx_data_q;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= send;
      ovf_q      <= ovf_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

`ifdef LOOPBACK_STATS_EN
  logic [15:0] rx_cnt_q, tx_cnt_q, drop_cnt_q;

  // Overflow drops and discards are mutually exclusive (a discard is a pop).
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push)            rx_cnt_q   <= rx_cnt_q + 1'b1;
      if (send)            tx_cnt_q   <= tx_cnt_q + 1'b1;
      if (drop | discard)  drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign rx_cnt   = rx_cnt_q;
  assign tx_cnt   = tx_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  assign rx_cnt   = '0;
  assign tx_cnt   = '0;
  assign drop_cnt = '0;
`endif

  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign fifo_count = count_q;
  assign empty      = empty_w;
  assign full       = full_w;
  assign ovf        = ovf_q;
  assign dbg_state  = state_q;

endmodule
